// File: rtl/rv_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// port identifiers and default geometry.
package rv_pkg;

   localparam int unsigned MEM_WORDS_DEF = 1024;
   localparam int unsigned IO_BIT_DEF    = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } rv_state_e;

   // Encoding of the last_grant flag.
   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/rv_rr_arb2.sv
// Two-input round-robin picker: on a tie, the port that did not win last
// time wins. Bit 0 is the instruction port, bit 1 the data port.
module rv_rr_arb2
   import rv_pkg::*;
(
   input  logic [1:0] reqs,
   input  logic       last_grant,
   output logic [1:0] winner
);

   always_comb begin
      winner = 2'b00;
      case (reqs)
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         2'b11:   winner = (last_grant == LAST_D) ? 2'b01 : 2'b10;
         default: winner = 2'b00;
      endcase
   end

endmodule

// File: rtl/rv_mem_arb.sv
// Arbitrates an instruction port and a data port onto one single-port RAM
// (1-cycle read latency); data accesses with d_addr[IO_BIT] set hit a 3-bit LED register.
module rv_mem_arb
   import rv_pkg::*;
#(
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
   parameter int unsigned IO_BIT    = IO_BIT_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_req,
   input  logic [31:0]                  i_addr,
   output logic                         i_gnt,
   output logic                         i_rvalid,
   output logic [31:0]                  i_rdata,
   input  logic                         d_req,
   input  logic                         d_we,
   input  logic [31:0]                  d_addr,
   input  logic [31:0]                  d_wdata,
   output logic                         d_gnt,
   output logic                         d_rvalid,
   output logic [31:0]                  d_rdata,
   output logic                         m_en,
   output logic                         m_we,
   output logic [$clog2(MEM_WORDS)-1:0] m_addr,
   output logic [31:0]                  m_wdata,
   input  logic [31:0]                  m_rdata,
   output logic [2:0]                   leds,
   output rv_state_e                    dbg_state
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   // Handshake: a request is held until its grant, which is asserted
   // combinationally in IDLE; the matching rvalid follows exactly one cycle later.
   rv_state_e   state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        io_q, io_d;
   logic [2:0]  leds_q, leds_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic [1:0]  win;
   logic        i_gnt_raw, d_gnt_raw, m_en_raw;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{i_addr, d_addr, d_wdata};

   rv_rr_arb2 u_rr (
      .reqs       ({d_req, i_req}),
      .last_grant (last_grant_q),
      .winner     (win)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      io_d         = io_q;
      leds_d       = leds_q;
      i_gnt_raw    = 1'b0;
      d_gnt_raw    = 1'b0;
      m_en_raw     = 1'b0;
      m_we         = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
      i_rvalid     = 1'b0;
      d_rvalid     = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (win[0]) begin
               i_gnt_raw    = 1'b1;
               m_en_raw     = 1'b1;
               m_addr       = i_addr[AW+1:2];
               last_grant_d = LAST_I;
               state_d      = BUSY_I;
            end else if (win[1]) begin
               d_gnt_raw    = 1'b1;
               last_grant_d = LAST_D;
               state_d      = BUSY_D;
               io_d         = d_addr[IO_BIT];
               if (d_addr[IO_BIT]) begin
                  if (d_we) leds_d = d_wdata[2:0];
               end else begin
                  m_en_raw = 1'b1;
                  m_we     = d_we;
                  m_addr   = d_addr[AW+1:2];
                  m_wdata  = d_wdata;
               end
            end
         end
         BUSY_I: begin
            i_rvalid  = 1'b1;
            i_rdata_d = m_rdata;
            state_d   = IDLE;
         end
         BUSY_D: begin
            d_rvalid  = 1'b1;
            d_rdata_d = io_q ? {29'b0, leds_q} : m_rdata;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read data is shown live during the response cycle and retained afterwards.
   assign i_rdata   = i_rdata_d;
   assign d_rdata   = d_rdata_d;
   assign i_gnt     = i_gnt_raw & reset;
   assign d_gnt     = d_gnt_raw & reset;
   assign m_en      = m_en_raw & reset;
   assign leds      = leds_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= LAST_D;
         io_q         <= 1'b0;
         leds_q       <= 3'b000;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         io_q         <= io_d;
         leds_q       <= leds_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: two instances (IO_BIT 12 and 13) share the
// request stimulus, each with its own behavioural single-port RAM.
module tb_rv_mem_arb;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;

   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
   logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
   logic [9:0]  m_addr;
   logic [2:0]  leds;
   rv_state_e   dbg_state;

   logic        i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, m_en_b, m_we_b;
   logic [31:0] i_rdata_b, d_rdata_b, m_wdata_b, m_rdata_b;
   logic [9:0]  m_addr_b;
   logic [2:0]  leds_b;
   rv_state_e   dbg_state_b;

   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rv_mem_arb #(.MEM_WORDS(1024), .IO_BIT(12)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .leds(leds), .dbg_state(dbg_state)
   );

   rv_mem_arb #(.MEM_WORDS(1024), .IO_BIT(13)) dut_b (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_b), .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
      .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_rdata(m_rdata_b),
      .leds(leds_b), .dbg_state(dbg_state_b)
   );

   // RAM models; contents are (re)initialised while reset is low.
   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 1024; k++) mem_a[k] <= 32'h0;
         mem_a[4] <= 32'h0050_0093;
         mem_a[8] <= 32'h1111_2222;
      end else if (m_en) begin
         if (m_we) mem_a[m_addr] <= m_wdata;
         else      m_rdata <= mem_a[m_addr];
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 1024; k++) mem_b[k] <= 32'h0;
      end else if (m_en_b) begin
         if (m_we_b) mem_b[m_addr_b] <= m_wdata_b;
         else        m_rdata_b <= mem_b[m_addr_b];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      i_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0;
      step(); step();
      i_req = 1'b1; d_req = 1'b1;
      @(negedge clk);
      checks++; if (i_gnt !== 1'b0) begin errors++; $display("FAIL rst_i_gnt got %b exp 0", i_gnt); end
      checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got %b exp 0", d_gnt); end
      checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rst_m_en got %b exp 0", m_en); end
      checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {i_rvalid, d_rvalid}); end
      checks++; if (leds !== 3'b000) begin errors++; $display("FAIL rst_leds got %b exp 000", leds); end
      checks++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {i_rdata, d_rdata}); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, IDLE); end
   endtask

   // Both requests held from reset release: grants alternate I, D, I, D.
   task automatic test_rr_after_reset();
      step();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if ({i_gnt, d_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_grant%0d got i=%b d=%b exp i=%0d", k, i_gnt, d_gnt, (k % 2 == 0));
         end
         step();
         if (k == 3) begin i_req = 1'b0; d_req = 1'b0; end
         @(negedge clk);
         checks++; if ({i_gnt, d_gnt, m_en} !== 3'b000) begin
            errors++; $display("FAIL rr_busy%0d got gnt/m_en=%b exp 000", k, {i_gnt, d_gnt, m_en});
         end
         if (k % 2 == 0) begin
            checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0050_0093) begin
               errors++; $display("FAIL rr_i_resp%0d got v=%b d=%h exp v=1 d=00500093", k, i_rvalid, i_rdata);
            end
         end else begin
            checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1111_2222) begin
               errors++; $display("FAIL rr_d_resp%0d got v=%b d=%h exp v=1 d=11112222", k, d_rvalid, d_rdata);
            end
         end
         step();
      end
   endtask

   task automatic test_fetch();
      i_req = 1'b1; i_addr = 32'h10;
      @(negedge clk);
      checks++; if (i_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 10'd4) begin
         errors++; $display("FAIL fetch_grant got gnt=%b en=%b we=%b addr=%0d exp 1 1 0 4", i_gnt, m_en, m_we, m_addr);
      end
      step();
      i_req = 1'b0;
      @(negedge clk);
      checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0050_0093) begin
         errors++; $display("FAIL fetch_resp got v=%b d=%h exp v=1 d=00500093", i_rvalid, i_rdata);
      end
      step();
      @(negedge clk);
      checks++; if (i_rvalid !== 1'b0 || i_rdata !== 32'h0050_0093) begin
         errors++; $display("FAIL fetch_hold got v=%b d=%h exp v=0 d=00500093", i_rvalid, i_rdata);
      end
      step();
   endtask

   task automatic test_io();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'h5;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1 || m_en !== 1'b0) begin
         errors++; $display("FAIL io_wr_grant got gnt=%b en=%b exp 1 0", d_gnt, m_en);
      end
      step();
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      checks++; if (leds !== 3'b101 || d_rvalid !== 1'b1) begin
         errors++; $display("FAIL io_wr_resp got leds=%b v=%b exp 101 1", leds, d_rvalid);
      end
      step();
      d_req = 1'b1;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1 || m_en !== 1'b0) begin
         errors++; $display("FAIL io_rd_grant got gnt=%b en=%b exp 1 0", d_gnt, m_en);
      end
      step();
      d_req = 1'b0;
      @(negedge clk);
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_0005) begin
         errors++; $display("FAIL io_rd_resp got v=%b d=%h exp v=1 d=00000005", d_rvalid, d_rdata);
      end
      step();
   endtask

   // Word 1023 written via 0x0FFC, read back via 0x1FFC on the IO_BIT=13 instance.
   task automatic test_wrap();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0FFC; d_wdata = 32'hCAFE_BABE;
      @(negedge clk);
      checks++; if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 10'd1023) begin
         errors++; $display("FAIL wrap_wr got en=%b we=%b addr=%0d exp 1 1 1023", m_en, m_we, m_addr);
      end
      step();
      d_req = 1'b0; d_we = 1'b0;
      step();
      d_req = 1'b1; d_addr = 32'h1FFC;
      @(negedge clk);
      checks++; if (m_en_b !== 1'b1 || m_addr_b !== 10'd1023 || m_en !== 1'b0) begin
         errors++; $display("FAIL wrap_rd_grant got en_b=%b addr_b=%0d en=%b exp 1 1023 0", m_en_b, m_addr_b, m_en);
      end
      step();
      d_req = 1'b0;
      @(negedge clk);
      checks++; if (d_rvalid_b !== 1'b1 || d_rdata_b !== 32'hCAFE_BABE) begin
         errors++; $display("FAIL wrap_rd13 got v=%b d=%h exp v=1 d=cafebabe", d_rvalid_b, d_rdata_b);
      end
      checks++; if (d_rdata !== 32'h0000_0005) begin
         errors++; $display("FAIL wrap_rd12_io got d=%h exp 00000005", d_rdata);
      end
      step();
   endtask

   task automatic test_busy_drop();
      i_req = 1'b1; i_addr = 32'h10;
      @(negedge clk);
      checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL drop_i_gnt got %b exp 1", i_gnt); end
      step();
      i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h0000_DEAD;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b0 || m_en !== 1'b0) begin
         errors++; $display("FAIL drop_busy got gnt=%b en=%b exp 0 0", d_gnt, m_en);
      end
      step();
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b0 || m_en !== 1'b0 || d_rvalid !== 1'b0) begin
         errors++; $display("FAIL drop_after got gnt=%b en=%b v=%b exp 0 0 0", d_gnt, m_en, d_rvalid);
      end
      step();
      checks++; if (mem_a[16] !== 32'h0) begin
         errors++; $display("FAIL drop_mem got %h exp 00000000", mem_a[16]);
      end
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'h6;
      @(negedge clk);
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b exp 1", d_gnt); end
      step();
      d_req = 1'b0; d_we = 1'b0;
      checks++; if (dbg_state !== BUSY_D || leds !== 3'b110) begin
         errors++; $display("FAIL mid_busy got state=%0d leds=%b exp %0d 110", dbg_state, leds, BUSY_D);
      end
      #2 reset = 1'b0;
      @(negedge clk);
      checks++; if (d_rvalid !== 1'b0 || dbg_state !== IDLE || leds !== 3'b000) begin
         errors++; $display("FAIL mid_reset got v=%b state=%0d leds=%b exp 0 %0d 000", d_rvalid, dbg_state, leds, IDLE);
      end
      step();
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20;
      step();
      reset = 1'b1;
      @(negedge clk);
      checks++; if ({i_gnt, d_gnt, d_rvalid} !== 3'b100) begin
         errors++; $display("FAIL mid_release got i=%b d=%b dv=%b exp 1 0 0", i_gnt, d_gnt, d_rvalid);
      end
      step();
      i_req = 1'b0; d_req = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_rr_after_reset();
      test_fetch();
      test_io();
      test_wrap();
      test_busy_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
